// File: rtl/sd_emmc_axi_wr_master.sv
// sd_emmc_axi_wr_master: single-beat AXI4 write master for the SD/eMMC DMA card-to-memory path
// Ports: clock/reset (sync, active-low); DMA side write_addr/addr_write_valid/addr_write_ready,
// fifo_dout/data_write_valid/next_data_word; AXI AW/W/B master channels; sticky bresp_err
// (bit0 SLVERR, bit1 DECERR) cleared by err_clr; wr_idle when nothing is in flight.
// Build option: define SD_EMMC_AXI_WR_POSTED_EN for posted writes with up to MAX_OUTSTANDING
// un-responded writes; otherwise each word waits for its write response.
module sd_emmc_axi_wr_master #(
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [3:0] AWCACHE_VAL     = 4'b0011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] write_addr,
    input  logic        addr_write_valid,
    output logic        addr_write_ready,
    input  logic        data_write_valid,
    input  logic [31:0] fifo_dout,
    output logic        next_data_word,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic [3:0]  m_axi_awcache,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [1:0]  bresp_err,
    input  logic        err_clr,
    output logic        wr_idle
);
    typedef enum logic [2:0] {IDLE, AW, AW_ACK, W_WAIT, W, B_WAIT} state_t;
    state_t     state;
    logic       posted, slot_free, b_hs;
    logic [1:0] bresp_set;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = AWCACHE_VAL;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = m_axi_wvalid;
    assign b_hs          = m_axi_bvalid & m_axi_bready;
    assign bresp_set     = b_hs ? {m_axi_bresp == 2'b11, m_axi_bresp == 2'b10} : 2'b00;
`ifdef SD_EMMC_AXI_WR_POSTED_EN
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    logic [CW-1:0] outstanding;
    logic          aw_hs;
    assign posted = 1'b1;
    assign aw_hs  = m_axi_awvalid & m_axi_awready;
    // A response retiring this cycle frees a slot immediately, so a stalled address goes out next cycle
    assign slot_free = (outstanding < CW'(MAX_OUTSTANDING)) || b_hs;
    assign wr_idle   = (state == IDLE) && (outstanding == '0);
    always_ff @(posedge clock) begin
        if (!reset)
            outstanding <= '0;
        else if (aw_hs && !b_hs)
            outstanding <= outstanding + 1'b1;
        else if (b_hs && !aw_hs)
            outstanding <= outstanding - 1'b1;
    end
`else
    assign posted    = 1'b0;
    assign slot_free = MAX_OUTSTANDING > 0;
    assign wr_idle   = state == IDLE;
`endif
    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            m_axi_awvalid    <= 1'b0;
            m_axi_awaddr     <= '0;
            m_axi_wvalid     <= 1'b0;
            m_axi_wdata      <= '0;
            m_axi_bready     <= 1'b0;
            addr_write_ready <= 1'b0;
            next_data_word   <= 1'b0;
        end else begin
            addr_write_ready <= 1'b0;
            next_data_word   <= 1'b0;
            if (posted) m_axi_bready <= 1'b1;
            case (state)
                IDLE: if (addr_write_valid && slot_free) begin
                    m_axi_awaddr  <= write_addr;
                    m_axi_awvalid <= 1'b1;
                    state         <= AW;
                end
                AW: if (m_axi_awready) begin
                    m_axi_awvalid    <= 1'b0;
                    addr_write_ready <= 1'b1;
                    state            <= AW_ACK;
                end
                // Data already waiting skips W_WAIT so wvalid follows the ack pulse directly
                AW_ACK: if (data_write_valid) begin
                    m_axi_wdata  <= fifo_dout;
                    m_axi_wvalid <= 1'b1;
                    state        <= W;
                end else begin
                    state <= W_WAIT;
                end
                W_WAIT: if (data_write_valid) begin
                    m_axi_wdata  <= fifo_dout;
                    m_axi_wvalid <= 1'b1;
                    state        <= W;
                end
                W: if (m_axi_wready) begin
                    m_axi_wvalid <= 1'b0;
                    if (posted) begin
                        next_data_word <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        m_axi_bready <= 1'b1;
                        state        <= B_WAIT;
                    end
                end
                B_WAIT: if (m_axi_bvalid) begin
                    m_axi_bready   <= 1'b0;
                    next_data_word <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // A new error in the same cycle as a clear survives the clear
    always_ff @(posedge clock) begin
        if (!reset)
            bresp_err <= 2'b00;
        else
            bresp_err <= (err_clr ? 2'b00 : bresp_err) | bresp_set;
    end
endmodule

// File: tb/tb_sd_emmc_axi_wr_master.sv
// tb_sd_emmc_axi_wr_master: scoreboarded bench for the AXI write master with a DMA driver and AXI slave model
module tb_sd_emmc_axi_wr_master;
`ifdef SD_EMMC_AXI_WR_POSTED_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 5;
`endif
    logic        clock = 1'b0, reset = 1'b0;
    logic [31:0] write_addr = '0, fifo_dout = '0;
    logic        addr_write_valid = 1'b0, data_write_valid = 1'b0;
    logic        addr_write_ready, next_data_word;
    logic [31:0] m_axi_awaddr, m_axi_wdata;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic [3:0]  m_axi_awcache, m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic [1:0]  bresp_err;
    logic        err_clr, wr_idle;
    logic        slave_clr = 1'b0, tb_clr = 1'b0;
    assign err_clr = slave_clr | tb_clr;
    int n_chk = 0, n_pass = 0, cyc = 0, n_w = 0;
    int aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    int b_grant = 0, b_used = 0;
    bit rnd = 1'b0, b_hold = 1'b0;
    logic [63:0] exp_aw[$], exp_w[$];
    logic [2:0]  resp_q[$], bq[$];
    sd_emmc_axi_wr_master #(.MAX_OUTSTANDING(4), .AWCACHE_VAL(4'b0011)) dut (
        .clock(clock), .reset(reset),
        .write_addr(write_addr), .addr_write_valid(addr_write_valid), .addr_write_ready(addr_write_ready),
        .data_write_valid(data_write_valid), .fifo_dout(fifo_dout), .next_data_word(next_data_word),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .bresp_err(bresp_err), .err_clr(err_clr), .wr_idle(wr_idle)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask
    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: condition not met (got 0, required 1)", name);
    endtask
    // AXI slave model and scoreboard monitor: readies decided at negedge, handshakes complete at next posedge
    always @(negedge clock) begin
        logic [2:0] r;
        slave_clr = 1'b0;
        if (!reset) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            exp_aw.delete();
            exp_w.delete();
            bq.delete();
            aw_wait = 0;
            w_wait  = 0;
        end else begin
            if (bq.size() > 0 && (!b_hold || b_grant > b_used)) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = bq[0][1:0];
                if (m_axi_bready) begin
                    slave_clr = bq[0][2];
                    if (b_hold) b_used++;
                    r = bq.pop_front();
                end
            end else begin
                m_axi_bvalid = 1'b0;
            end
            if (m_axi_awvalid) begin
                if (exp_aw.size() == 0) fail("aw_unexpected");
                else check("awaddr", m_axi_awaddr, exp_aw[0][63:32]);
                m_axi_awready = aw_wait >= aw_delay;
                if (m_axi_awready) begin
                    aw_wait = 0;
                    if (exp_aw.size() > 0) exp_w.push_back(exp_aw.pop_front());
                    if (rnd) aw_delay = $urandom_range(0, 3);
                end else begin
                    aw_wait++;
                end
            end else begin
                m_axi_awready = 1'b0;
            end
            if (m_axi_wvalid) begin
                if (exp_w.size() == 0) fail("w_unexpected");
                else check("wdata", m_axi_wdata, exp_w[0][31:0]);
                m_axi_wready = w_wait >= w_delay;
                if (m_axi_wready) begin
                    w_wait = 0;
                    check("wstrb", m_axi_wstrb, 4'hF);
                    check("wlast", m_axi_wlast, 1'b1);
                    if (exp_w.size() > 0) r = exp_w.pop_front();
                    n_w++;
                    r = resp_q.size() > 0 ? resp_q.pop_front() : 3'b000;
                    bq.push_back(r);
                    if (rnd) w_delay = $urandom_range(0, 3);
                end else begin
                    w_wait++;
                end
            end else begin
                m_axi_wready = 1'b0;
            end
        end
    end
    // DMA model: present address and data together, retire on next_data_word
    task automatic do_word(input logic [31:0] a, input logic [31:0] d, output int lat, output int np);
        int  t0;
        bit  got;
        write_addr       = a;
        fifo_dout        = d;
        addr_write_valid = 1'b1;
        data_write_valid = 1'b1;
        exp_aw.push_back({a, d});
        t0  = cyc;
        got = 1'b0;
        np  = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clock);
            if (addr_write_ready) begin
                np++;
                addr_write_valid = 1'b0;
            end
            if (next_data_word) got = 1'b1;
        end
        if (!got) fail("ndw_timeout");
        lat = cyc - t0;
        addr_write_valid = 1'b0;
        data_write_valid = 1'b0;
        @(negedge clock);
        check("pulses_one_cycle", {next_data_word, addr_write_ready}, 2'b00);
    endtask
    initial begin
        int lat, np, base_w;
        repeat (3) @(negedge clock);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, addr_write_ready, next_data_word}, 5'b0);
        check("rst_awaddr", m_axi_awaddr, 32'h0);
        check("rst_wdata", m_axi_wdata, 32'h0);
        check("rst_bresp_err", bresp_err, 2'b00);
        check("rst_wr_idle", wr_idle, 1'b1);
        check("const_aw", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot},
              {8'd0, 3'b010, 2'b01, 4'b0011, 3'd0});
        reset = 1'b1;
        @(negedge clock);
        do_word(32'h1000_0000, 32'hA5A5_5A5A, lat, np);
        check("min_latency", lat, LAT);
        check("awr_pulses_fast", np, 1);
        repeat (4) @(negedge clock);
        check("bresp_err_okay", bresp_err, 2'b00);
        check("idle_after_word", wr_idle, 1'b1);
        aw_delay = 7;
        w_delay  = 3;
        do_word(32'h1000_0004, 32'h1234_5678, lat, np);
        check("stall_latency", lat, LAT + 10);
        check("awr_pulses_stall", np, 1);
        aw_delay = 0;
        w_delay  = 0;
        resp_q.push_back(3'b010);
        resp_q.push_back(3'b011);
        do_word(32'h1000_0008, 32'h0000_0001, lat, np);
        do_word(32'h1000_000C, 32'h0000_0002, lat, np);
        repeat (4) @(negedge clock);
        check("bresp_err_both", bresp_err, 2'b11);
        resp_q.push_back(3'b110);
        do_word(32'h1000_0010, 32'h0000_0003, lat, np);
        repeat (4) @(negedge clock);
        check("clr_vs_slverr", bresp_err, 2'b01);
        tb_clr = 1'b1;
        @(negedge clock);
        tb_clr = 1'b0;
        @(negedge clock);
        check("clr_only", bresp_err, 2'b00);
        resp_q.push_back(3'b011);
        do_word(32'h1000_0014, 32'h0000_0004, lat, np);
        repeat (4) @(negedge clock);
        check("decerr_only", bresp_err, 2'b10);
        w_delay = 20;
        write_addr       = 32'h1000_0018;
        fifo_dout        = 32'h0000_0005;
        addr_write_valid = 1'b1;
        data_write_valid = 1'b1;
        exp_aw.push_back({write_addr, fifo_dout});
        for (int i = 0; i < 50 && !m_axi_wvalid; i++) @(negedge clock);
        if (!m_axi_wvalid) fail("reach_w_state");
        reset            = 1'b0;
        addr_write_valid = 1'b0;
        data_write_valid = 1'b0;
        @(negedge clock);
        check("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b000);
        check("midrst_bresp_err", bresp_err, 2'b00);
        check("midrst_idle", wr_idle, 1'b1);
        reset   = 1'b1;
        w_delay = 0;
        @(negedge clock);
`ifdef SD_EMMC_AXI_WR_POSTED_EN
        check("posted_bready", m_axi_bready, 1'b1);
        b_hold  = 1'b1;
        b_grant = b_used;
        for (int i = 0; i < 4; i++) do_word(32'h3000_0000 + 32'(i * 4), 32'h5500_0000 + 32'(i), lat, np);
        write_addr       = 32'h3000_0010;
        fifo_dout        = 32'h5500_0004;
        addr_write_valid = 1'b1;
        data_write_valid = 1'b1;
        exp_aw.push_back({write_addr, fifo_dout});
        repeat (6) @(negedge clock);
        check("stall_awvalid", m_axi_awvalid, 1'b0);
        check("stall_not_idle", wr_idle, 1'b0);
        @(posedge clock);
        b_grant = b_used + 1;
        @(negedge clock);
        @(negedge clock);
        check("release_awvalid", m_axi_awvalid, 1'b1);
        for (int i = 0; i < 50 && !next_data_word; i++) begin
            @(negedge clock);
            if (addr_write_ready) addr_write_valid = 1'b0;
        end
        check("released_word_done", next_data_word, 1'b1);
        addr_write_valid = 1'b0;
        data_write_valid = 1'b0;
        b_hold = 1'b0;
        repeat (10) @(negedge clock);
`endif
        rnd    = 1'b1;
        base_w = n_w;
        for (int i = 0; i < 128; i++) begin
            do_word(32'h2000_0000 + 32'(i * 4), 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101), lat, np);
            if (np != 1) check("burst_awr_pulses", np, 1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        rnd      = 1'b0;
        aw_delay = 0;
        w_delay  = 0;
        for (int i = 0; i < 50 && !(wr_idle && bq.size() == 0); i++) @(negedge clock);
        check("burst_writes", n_w - base_w, 128);
        check("burst_idle", wr_idle, 1'b1);
        check("burst_queues_drained", exp_aw.size() + exp_w.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
